// File: rtl/dot_product_seq.sv
// dot_product_seq
// Streaming dot-product engine. LANES element pairs arrive per accepted beat
// and are multiplied and accumulated over N_ELEM elements. The finished sum
// is then held on a registered valid/ready output until it is consumed.
// Build option: define DOT_PRODUCT_SIGNED_EN for two's-complement operands
// and result. Without it, operands are unsigned and zero-extended.
module dot_product_seq #(
   parameter int N_ELEM = 4,
   parameter int W      = 32,
   parameter int LANES  = 1,
   parameter int ACC_W  = 2*W + $clog2(N_ELEM) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [LANES*W-1:0] in_x,
   input  logic [LANES*W-1:0] in_y,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACC_W-1:0]   out_result,
   output logic [31:0]        out_count
);

   localparam int BEATS = N_ELEM / LANES;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   // Products are formed at the wider of 2W and ACC_W, so that a narrowed
   // ACC_W simply truncates the result.
   localparam int EXT_W = (ACC_W > 2*W) ? ACC_W : 2*W;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] beat_cnt;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] beat_sum;
   logic             accept;
   logic             abort;
   logic             final_beat;
   logic             release_res;

   // Full 2W-bit product of one lane pair, extended to ACC_W. The extension
   // follows operand signedness. If ACC_W < 2W, the upper bits are discarded.
   function automatic logic [ACC_W-1:0] lane_product(input logic [W-1:0] a,
                                                     input logic [W-1:0] b);
`ifdef DOT_PRODUCT_SIGNED_EN
      logic signed [2*W-1:0]   a_ext;
      logic signed [2*W-1:0]   b_ext;
      logic signed [2*W-1:0]   prod;
      logic signed [EXT_W-1:0] prod_ext;
      a_ext    = $signed({{W{a[W-1]}}, a});
      b_ext    = $signed({{W{b[W-1]}}, b});
      prod     = a_ext * b_ext;
      prod_ext = EXT_W'(prod);
`else
      logic [2*W-1:0]   a_ext;
      logic [2*W-1:0]   b_ext;
      logic [2*W-1:0]   prod;
      logic [EXT_W-1:0] prod_ext;
      a_ext    = {{W{1'b0}}, a};
      b_ext    = {{W{1'b0}}, b};
      prod     = a_ext * b_ext;
      prod_ext = EXT_W'(prod);
`endif
      return prod_ext[ACC_W-1:0];
   endfunction

   // Accumulator addition. It wraps modulo 2^ACC_W with no overflow flag, and
   // is the same operation for signed and unsigned operands.
   function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
      logic [ACC_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[ACC_W-1:0];
   endfunction

   // Sum of the LANES products of the beat currently presented.
   always_comb begin
      beat_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         beat_sum = acc_add(beat_sum, lane_product(in_x[i*W +: W], in_y[i*W +: W]));
      end
   end

   // Handshake qualifiers. clr in ACCUM beats any beat, including the final one.
   always_comb begin
      accept      = (state == ACCUM) && in_valid && !clr;
      abort       = (state == ACCUM) && clr;
      final_beat  = accept && (beat_cnt == LAST_BEAT);
      release_res = (state == HOLD) && out_ready;
   end

   // Next-state logic. in_ready depends on state alone.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         ACCUM: begin
            in_ready = 1'b1;
            if (final_beat) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_nxt = ACCUM;
            end
         end
         default: state_nxt = ACCUM;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   // Running accumulator and beat position within the current vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         beat_cnt <= '0;
      end else if (abort || final_beat) begin
         acc      <= '0;
         beat_cnt <= '0;
      end else if (accept) begin
         acc      <= acc_add(acc, beat_sum);
         beat_cnt <= beat_cnt + CNT_W'(1);
      end
   end

   // Result register. It is loaded with the final sum and held until consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_result <= '0;
         out_valid  <= 1'b0;
      end else if (final_beat) begin
         out_result <= acc_add(acc, beat_sum);
         out_valid  <= 1'b1;
      end else if (release_res) begin
         out_valid  <= 1'b0;
      end
   end

   // Count of delivered results. It wraps naturally at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_count <= '0;
      end else if (release_res) begin
         out_count <= out_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_dot_product_seq.sv
// tb_dot_product_seq
// Drives three configurations of dot_product_seq side by side:
//   0: W=32, N_ELEM=4, LANES=1
//   1: W=8,  N_ELEM=4, LANES=4 (one beat per vector)
//   2: W=16, N_ELEM=6, LANES=2
// Each configuration has a reference model. The model collects elements into
// a list and forms the dot product with plain arithmetic.
module tb_dot_product_seq;

   localparam int NCFG = 3;
   localparam int CW [NCFG] = '{32, 8, 16};
   localparam int CN [NCFG] = '{4, 4, 6};
   localparam int CL [NCFG] = '{1, 4, 2};
   localparam int CA [NCFG] = '{67, 19, 36};

`ifdef DOT_PRODUCT_SIGNED_EN
   localparam logic [127:0] LIT_ALL_ONES = 128'd4;
   localparam logic [127:0] LIT_MIXED    = 128'd508020;   // -16268 mod 2^19
`else
   localparam logic [127:0] LIT_ALL_ONES = 128'd260100;
   localparam logic [127:0] LIT_MIXED    = 128'd17268;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic [NCFG-1:0]       clr;
   logic [NCFG-1:0]       in_valid;
   logic [NCFG-1:0]       out_ready;
   logic [NCFG-1:0][31:0] in_x;
   logic [NCFG-1:0][31:0] in_y;
   wire  [NCFG-1:0]       rdy;
   wire  [NCFG-1:0]       vld;
   wire  [31:0]           cnt0, cnt1, cnt2;
   wire  [66:0]           res0;
   wire  [18:0]           res1;
   wire  [35:0]           res2;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   // Reference model state
   logic [31:0]     mx [NCFG][8];
   logic [31:0]     my [NCFG][8];
   int              mcnt [NCFG];
   bit [NCFG-1:0]   pend;
   logic [127:0]    mres [NCFG];
   logic [31:0]     mcount [NCFG];

   always #5 clk = ~clk;

   dot_product_seq #(.N_ELEM(4), .W(32), .LANES(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .clr(clr[0]), .in_valid(in_valid[0]), .in_ready(rdy[0]),
      .in_x(in_x[0]), .in_y(in_y[0]), .out_valid(vld[0]), .out_ready(out_ready[0]),
      .out_result(res0), .out_count(cnt0));

   dot_product_seq #(.N_ELEM(4), .W(8), .LANES(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .clr(clr[1]), .in_valid(in_valid[1]), .in_ready(rdy[1]),
      .in_x(in_x[1]), .in_y(in_y[1]), .out_valid(vld[1]), .out_ready(out_ready[1]),
      .out_result(res1), .out_count(cnt1));

   dot_product_seq #(.N_ELEM(6), .W(16), .LANES(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .clr(clr[2]), .in_valid(in_valid[2]), .in_ready(rdy[2]),
      .in_x(in_x[2]), .in_y(in_y[2]), .out_valid(vld[2]), .out_ready(out_ready[2]),
      .out_result(res2), .out_count(cnt2));

   function automatic logic [127:0] res_of(input int c);
      case (c)
         0:       return {61'd0, res0};
         1:       return {109'd0, res1};
         default: return {92'd0, res2};
      endcase
   endfunction

   function automatic logic [31:0] cnt_of(input int c);
      case (c)
         0:       return cnt0;
         1:       return cnt1;
         default: return cnt2;
      endcase
   endfunction

   // Element value as a 128-bit integer, honouring operand signedness.
   function automatic logic signed [127:0] ext(input logic [31:0] v, input int w);
      logic signed [127:0] r;
      r = '0;
      for (int b = 0; b < w; b++) r[b] = v[b];
`ifdef DOT_PRODUCT_SIGNED_EN
      for (int b = w; b < 128; b++) r[b] = v[w-1];
`endif
      return r;
   endfunction

   // Dot product of the collected vector, reduced modulo 2^ACC_W.
   function automatic logic [127:0] dot(input int c);
      logic signed [127:0] s;
      s = '0;
      for (int i = 0; i < CN[c]; i++) s = s + ext(mx[c][i], CW[c]) * ext(my[c][i], CW[c]);
      return s & ((128'd1 << CA[c]) - 128'd1);
   endfunction

   task automatic chk(input string nm, input int c, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 50)
            $display("FAIL %s cfg%0d: got %0h, expected %0h at %0t", nm, c, act, exp, $time);
      end
   endtask

   // Reference model. An accepted beat appends its lanes to the element list.
   // A full list yields a pending result. Consuming that result bumps the count.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         for (int c = 0; c < NCFG; c++) begin
            if (!rst_n) begin
               mcnt[c]   = 0;
               pend[c]   = 1'b0;
               mres[c]   = '0;
               mcount[c] = '0;
            end else if (pend[c]) begin
               if (out_ready[c]) begin
                  pend[c]   = 1'b0;
                  mcount[c] = mcount[c] + 32'd1;
               end
            end else if (clr[c]) begin
               mcnt[c] = 0;
            end else if (in_valid[c]) begin
               for (int i = 0; i < CL[c]; i++) begin
                  mx[c][mcnt[c]] = in_x[c] >> (i * CW[c]);
                  my[c][mcnt[c]] = in_y[c] >> (i * CW[c]);
                  mcnt[c]++;
               end
               if (mcnt[c] == CN[c]) begin
                  mres[c] = dot(c);
                  pend[c] = 1'b1;
                  mcnt[c] = 0;
               end
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            for (int c = 0; c < NCFG; c++) begin
               chk("in_ready", c, 128'(rdy[c]), 128'(!pend[c]));
               chk("out_valid", c, 128'(vld[c]), 128'(pend[c]));
               chk("out_result", c, res_of(c), mres[c]);
               chk("out_count", c, 128'(cnt_of(c)), 128'(mcount[c]));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input int c, input logic [31:0] x, input logic [31:0] y, input bit v);
      in_valid[c] = v;
      in_x[c]     = x;
      in_y[c]     = y;
      step();
   endtask

   // Called right after the final beat's edge: the result must be visible now.
   task automatic expect_result(input int c, input logic [127:0] lit, input string nm);
      in_valid[c] = 1'b0;
      @(negedge clk);
      chk({nm, "_valid"}, c, 128'(vld[c]), 128'd1);
      chk(nm, c, res_of(c), lit);
   endtask

   initial begin
      rst_n     = 1'b0;
      clr       = '0;
      in_valid  = '0;
      out_ready = '0;
      in_x      = '0;
      in_y      = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      cmp_en = 1'b1;
      for (int c = 0; c < NCFG; c++) begin
         chk("rst_valid", c, 128'(vld[c]), 128'd0);
         chk("rst_ready", c, 128'(rdy[c]), 128'd1);
         chk("rst_count", c, 128'(cnt_of(c)), 128'd0);
         chk("rst_result", c, res_of(c), 128'd0);
      end
      rst_n = 1'b1;

      // Basic vector with the consumer stalled for three cycles
      beat(0, 1, 5, 1); beat(0, 2, 6, 1); beat(0, 3, 7, 1); beat(0, 4, 8, 1);
      expect_result(0, 128'd70, "basic");
      chk("hold_ready", 0, 128'(rdy[0]), 128'd0);
      repeat (3) step();
      @(negedge clk);
      chk("hold_result", 0, res_of(0), 128'd70);
      chk("hold_ready2", 0, 128'(rdy[0]), 128'd0);
      out_ready[0] = 1'b1;
      step();
      @(negedge clk);
      chk("release_count", 0, 128'(cnt0), 128'd1);
      chk("release_ready", 0, 128'(rdy[0]), 128'd1);

      // Gaps in in_valid: the junk on invalid cycles must be ignored
      beat(0, 1, 1, 1); beat(0, 100, 100, 0); beat(0, 2, 2, 1); beat(0, 100, 100, 0);
      beat(0, 3, 3, 1); beat(0, 100, 100, 0); beat(0, 4, 4, 1);
      expect_result(0, 128'd30, "gaps");
      step();

      // Abort after two beats; the beat presented with clr is dropped
      beat(0, 9, 9, 1); beat(0, 9, 9, 1);
      clr[0] = 1'b1;
      beat(0, 9, 9, 1);
      clr[0] = 1'b0;
      beat(0, 1, 1, 1); beat(0, 1, 1, 1); beat(0, 1, 1, 1); beat(0, 1, 1, 1);
      expect_result(0, 128'd4, "clr");
      step();

      // Asynchronous reset mid-vector
      beat(0, 7, 7, 1); beat(0, 7, 7, 1);
      rst_n       = 1'b0;
      in_valid[0] = 1'b0;
      @(negedge clk);
      chk("midrst_valid", 0, 128'(vld[0]), 128'd0);
      chk("midrst_count", 0, 128'(cnt0), 128'd0);
      rst_n = 1'b1;
      beat(0, 2, 1, 1); beat(0, 3, 1, 1); beat(0, 4, 1, 1); beat(0, 5, 1, 1);
      expect_result(0, 128'd14, "post_rst");
      step();

      // Four lanes, one beat per vector
      out_ready[1] = 1'b1;
      beat(1, 32'h0504_0302, 32'h0A0A_0A0A, 1);
      expect_result(1, 128'd140, "one_beat");
      step();
      beat(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      expect_result(1, LIT_ALL_ONES, "all_ones");
      step();
      beat(1, 32'h0000_7FFD, 32'h0000_8004, 1);
      expect_result(1, LIT_MIXED, "mixed");
      step();

      // Two lanes, three beats
      beat(2, 32'h0002_0001, 32'h0001_0001, 1);
      beat(2, 32'h0004_0003, 32'h0001_0001, 1);
      beat(2, 32'h0006_0005, 32'h0001_0001, 1);
      expect_result(2, 128'd21, "lanes2");
      out_ready[2] = 1'b1;
      step();

      // Randomised traffic on all configurations, with occasional resets
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < NCFG; c++) begin
            in_valid[c]  = ($urandom_range(3) != 0);
            out_ready[c] = ($urandom_range(2) != 0);
            clr[c]       = ($urandom_range(24) == 0);
            in_x[c]      = ($urandom_range(5) == 0) ? 32'hFFFF_FFFF : $urandom;
            in_y[c]      = ($urandom_range(5) == 0) ? 32'hFFFF_FFFF : $urandom;
         end
         rst_n = ($urandom_range(799) != 0);
         step();
      end
      rst_n    = 1'b1;
      clr      = '0;
      in_valid = '0;
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dot_product_seq.md
# dot_product_seq

Streaming, parametrised dot-product engine. It accepts vector element pairs over a valid/ready handshake, LANES pairs per beat, and multiplies and accumulates them over N_ELEM elements. It then presents one full-width result on a second valid/ready handshake. It sits between the operand fetch stage and the result writeback stage of the algebra datapath, and replaces the single-cycle fixed four-element scalar product.

## Interface
Parameters:
- N_ELEM, 4: elements per vector. Must be ≥ 1 and a multiple of LANES.
- W, 32: element width in bits.
- LANES, 1: element pairs consumed per accepted beat.
- ACC_W, 2*W+$clog2(N_ELEM)+1: accumulator and result width.

Ports:
- clk, in, 1: single clock; all state is updated on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- clr, in, 1: synchronous abort; discards any partial vector.
- in_valid, in, 1: operand beat is valid.
- in_ready, out, 1: engine accepts a beat this cycle.
- in_x, in, LANES*W: X elements; lane i is at [i*W +: W], and lane 0 is the lower element index.
- in_y, in, LANES*W: Y elements, same packing as in_x.
- out_valid, out, 1: result is valid.
- out_ready, in, 1: consumer accepts the result.
- out_result, out, ACC_W: dot product.
- out_count, out, 32: free-running count of completed results; wraps at 2^32.

## Operation
- BEATS = N_ELEM/LANES. The beat counter beat_cnt has width $clog2(BEATS) and is at least 1 bit.
- The state machine has two states: ACCUM and HOLD.
  - ACCUM: in_ready=1. A beat is accepted when in_valid && in_ready. Each accepted beat adds the sum of the LANES products to acc.
  - ACCUM → HOLD: on accepting the beat with beat_cnt==BEATS-1. On that edge, out_result ← acc + beat_sum; acc ← 0; beat_cnt ← 0; out_valid ← 1.
  - HOLD: in_ready=0. out_result and out_valid are held stable.
  - HOLD → ACCUM: on out_valid && out_ready. On that edge, out_valid ← 0 and out_count ← out_count+1.
- Arithmetic:
  - Each product is the full 2W-bit result.
  - Lane sums and acc are extended to ACC_W before addition.
  - If ACC_W is below the default, results are truncated modulo 2^ACC_W, with no flag.
- clr:
  - In ACCUM: acc ← 0 and beat_cnt ← 0; any beat presented in the same cycle is dropped.
  - In HOLD: no effect; the pending result is still delivered.
- Reset, asynchronous, including mid-vector: state=ACCUM, acc=0, beat_cnt=0, out_valid=0, out_result=0, out_count=0. in_ready is combinational from state and reads 1 after reset.
- Gaps in in_valid do not alter acc or beat_cnt.

## Timing
- Throughput: one beat per cycle while in ACCUM.
- Latency: out_valid is high on the cycle after the final beat is accepted.
- Result cadence: at best one result every BEATS+1 cycles. This occurs when out_ready=1 in the first HOLD cycle. HOLD lasts at least one cycle, and beats are never accepted in the same cycle as the result handshake.
- in_ready depends only on state; it has no combinational path from in_valid or out_ready.
- out_* are registered.
- Simultaneous clr and final beat: clr wins; no result is produced.

## Configuration
- DOT_PRODUCT_SIGNED_EN:
  - Defined: in_x and in_y lanes are two's-complement. Products and sums are sign-extended to ACC_W, and out_result is two's-complement.
  - Undefined: all operands are unsigned and zero-extended.
- The state machine and timing are identical in both builds.

## Test plan
All scenarios use default W=32 and LANES=1 unless stated.
- **Basic, N_ELEM=4:** beats x=1,2,3,4 with y=5,6,7,8 on consecutive cycles → out_valid one cycle after the fourth beat, out_result=70, out_count=1.
- **One-beat vector, LANES=4, N_ELEM=4:** single beat, x lanes 2,3,4,5 and y lanes 10,10,10,10 → out_result=140 on the next cycle; beat_cnt stays 0.
- **Backpressure and gaps:**
  - in_valid toggles 1,0,1,0,... across the vector → acc advances only on valid cycles.
  - out_ready held low for 3 cycles → out_result held, in_ready=0 throughout.
  - Release out_ready → handshake, in_ready=1 on the next cycle.
- **Width corner, W=8, N_ELEM=4, unsigned:** all elements 255 → out_result=260100 with no truncation (ACC_W=19).
- **Signed build, DOT_PRODUCT_SIGNED_EN, W=8, N_ELEM=2:** x=-3,127 and y=4,-128 → out_result=-16268.
- **Abort and reset:**
  - clr after 2 of 4 beats, then a fresh vector 1,1,1,1 · 1,1,1,1 → out_result=4.
  - rst_n low mid-vector → out_valid=0, out_count=0, and the next full vector produces a correct result.
